// File: rtl/pmem_pkg.sv
// Shared types and defaults for the program-memory read arbiter.
package pmem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAITING  = 2'd1,
        RELAYING = 2'd2
    } ch_state_t;

    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 16;

    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pmem_rr_picker.sv
// Round-robin pick: first set bit of the eligible mask at or after the start pointer.
module pmem_rr_picker
    import pmem_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_bits(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] start_ptr,
    output logic          found,
    output logic [PW-1:0] winner
);

    logic [PW-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(start_ptr) + i) % N);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares program-memory read channels among instruction fetchers,
// round-robin grant per idle channel, relaying data back with valid/ready.
module pmem_arbiter
    import pmem_pkg::*;
#(
    parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 consumer_read_valid   [NUM_CONSUMERS-1:0],
    input  logic [ADDR_BITS-1:0] consumer_read_address [NUM_CONSUMERS-1:0],
    output logic                 consumer_read_ready   [NUM_CONSUMERS-1:0],
    output logic [DATA_BITS-1:0] consumer_read_data    [NUM_CONSUMERS-1:0],
    output logic                 mem_read_valid        [NUM_CHANNELS-1:0],
    output logic [ADDR_BITS-1:0] mem_read_address      [NUM_CHANNELS-1:0],
    input  logic                 mem_read_ready        [NUM_CHANNELS-1:0],
    input  logic [DATA_BITS-1:0] mem_read_data         [NUM_CHANNELS-1:0]
);

    localparam int PW = ptr_bits(NUM_CONSUMERS);

    ch_state_t                state_q [NUM_CHANNELS-1:0];
    ch_state_t                state_d [NUM_CHANNELS-1:0];
    logic [PW-1:0]            owner_q [NUM_CHANNELS-1:0];
    logic [PW-1:0]            rr_ptr;
    logic [PW-1:0]            rr_next;

    logic [NUM_CONSUMERS-1:0] owned;
    logic [NUM_CONSUMERS-1:0] eligible;
    logic [NUM_CHANNELS-1:0]  found;
    logic [NUM_CHANNELS-1:0]  grant;
    logic [PW-1:0]            pick [NUM_CHANNELS-1:0];
    logic                     any_grant;
    logic [PW-1:0]            last_win;

    always_comb begin
        owned = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (state_q[ch] != IDLE) owned[owner_q[ch]] = 1'b1;
        end
        for (int c = 0; c < NUM_CONSUMERS; c++) begin
            eligible[c] = consumer_read_valid[c] && !owned[c]
                          && !consumer_read_ready[c];
        end
    end

    // Each channel sees the mask left over by lower-indexed channels.
    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
        logic [NUM_CONSUMERS-1:0] avail;
        logic [NUM_CONSUMERS-1:0] left;
        logic [NUM_CONSUMERS-1:0] win_bit;

        if (ch == 0) begin : g_first
            assign avail = eligible;
        end else begin : g_next
            assign avail = g_ch[ch-1].left;
        end

        pmem_rr_picker #(
            .N  (NUM_CONSUMERS),
            .PW (PW)
        ) u_pick (
            .eligible  (avail),
            .start_ptr (rr_ptr),
            .found     (found[ch]),
            .winner    (pick[ch])
        );

        // A stale memory ready blocks the grant so it cannot complete it.
        assign grant[ch] = (state_q[ch] == IDLE) && !mem_read_ready[ch]
                           && found[ch];
        assign win_bit   = NUM_CONSUMERS'(1) << pick[ch];
        assign left      = grant[ch] ? (avail & ~win_bit) : avail;
    end

    always_comb begin
        any_grant = 1'b0;
        last_win  = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (grant[ch]) begin
                any_grant = 1'b1;
                last_win  = pick[ch];
            end
        end
        rr_next = (int'(last_win) == NUM_CONSUMERS - 1) ? '0
                : last_win + PW'(1);
    end

    always_comb begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_d[ch] = state_q[ch];
            unique case (state_q[ch])
                IDLE:
                    if (grant[ch]) state_d[ch] = WAITING;
                WAITING:
                    if (mem_read_ready[ch]) state_d[ch] = RELAYING;
                RELAYING:
                    if (!consumer_read_valid[owner_q[ch]]) state_d[ch] = IDLE;
                default:
                    state_d[ch] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch]          <= IDLE;
                owner_q[ch]          <= '0;
                mem_read_valid[ch]   <= 1'b0;
                mem_read_address[ch] <= '0;
            end
            for (int c = 0; c < NUM_CONSUMERS; c++) begin
                consumer_read_ready[c] <= 1'b0;
                consumer_read_data[c]  <= '0;
            end
        end else begin
            if (any_grant) rr_ptr <= rr_next;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= state_d[ch];
                if (grant[ch]) begin
                    mem_read_valid[ch]   <= 1'b1;
                    mem_read_address[ch] <= consumer_read_address[pick[ch]];
                    owner_q[ch]          <= pick[ch];
                end
                if (state_q[ch] == WAITING && mem_read_ready[ch]) begin
                    mem_read_valid[ch]                   <= 1'b0;
                    consumer_read_ready[owner_q[ch]]     <= 1'b1;
                    consumer_read_data[owner_q[ch]]      <= mem_read_data[ch];
                end
                if (state_q[ch] == RELAYING
                    && !consumer_read_valid[owner_q[ch]]) begin
                    consumer_read_ready[owner_q[ch]] <= 1'b0;
                    consumer_read_data[owner_q[ch]]  <= '0;
                end
            end
        end
    end

endmodule
